// File: rtl/shift_deserializer_pkg.sv
// Shared types and constants for the serial-to-parallel deserializer.
package shift_deserializer_pkg;

  localparam int DEFAULT_WIDTH = 4;

  // IDLE: no bits of the current word held; SHIFT: 1..WIDTH-1 bits held.
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

endpackage

// File: rtl/deser_bit_counter.sv
// Counts accepted serial bits within a word and flags the last bit position.
module deser_bit_counter
  import shift_deserializer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  localparam int CW   = (WIDTH > 2) ? $clog2(WIDTH) : 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tc = (cnt_q == CW'(WIDTH - 1));

  // Next count: a clear restarts the word, and a bit arriving with the clear
  // is already bit 1 of the new word; wrap to 0 after the last bit.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = en ? CW'(1) : '0;
    end else if (en) begin
      cnt_d = tc ? '0 : cnt_q + 1'b1;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/shift_deserializer.sv
// Serial-to-parallel deserializer with selectable bit order, frame sync,
// a single-entry output register and a sticky overrun flag.
//
// Output handshake: Data_Out is offered while Out_Valid = 1 and is taken on
// any cycle where Out_Valid = 1 and Out_Ready = 1; Data_Out stays stable
// until taken, and a word completing while an untaken word is held is
// dropped and recorded in Overrun.
module shift_deserializer
  import shift_deserializer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Ser_In,
  input  logic             Ser_Valid,
  input  logic             Dir,
  input  logic             Sync,
  input  logic             Out_Ready,
  input  logic             Clr_Ovr,
  output logic [WIDTH-1:0] Data_Out,
  output logic             Out_Valid,
  output logic             Busy,
  output logic             Overrun
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             out_valid_q, out_valid_d;
  logic             ovr_q, ovr_d;

  logic             tc;
  logic             first_bit;
  logic             dir_eff;
  logic [WIDTH-1:0] sh_base;
  logic [WIDTH-1:0] sh_next;
  logic             word_done;
  logic             consume;
  logic             ovr_event;

  deser_bit_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk (clk),
    .rst (rst),
    .clr (Sync),
    .en  (Ser_Valid),
    .tc  (tc)
  );

  assign Data_Out  = data_q;
  assign Out_Valid = out_valid_q;
  assign Busy      = (state_q == SHIFT);
  assign Overrun   = ovr_q;

  // Shift path: the order bit is taken live on the first bit of a word
  // (from IDLE, or the bit arriving with Sync) and held for the rest.
  always_comb begin
    first_bit = Sync || (state_q == IDLE);
    dir_eff   = first_bit ? Dir : dir_q;
    sh_base   = Sync ? '0 : sh_q;
    sh_next   = dir_eff ? {sh_base[WIDTH-2:0], Ser_In}
                        : {Ser_In, sh_base[WIDTH-1:1]};
    word_done = Ser_Valid && tc && !Sync;

    state_d = state_q;
    sh_d    = sh_q;
    dir_d   = dir_q;
    if (Sync) begin
      sh_d    = '0;
      state_d = IDLE;
    end
    if (Ser_Valid) begin
      dir_d = dir_eff;
      if (word_done) begin
        sh_d    = '0;
        state_d = IDLE;
      end else begin
        sh_d    = sh_next;
        state_d = SHIFT;
      end
    end
  end

  // Output register: a completed word loads if the slot is empty or being
  // taken this same cycle; otherwise it is dropped and Overrun is raised.
  always_comb begin
    consume     = out_valid_q && Out_Ready;
    data_d      = data_q;
    out_valid_d = out_valid_q;
    ovr_event   = 1'b0;
    if (consume) begin
      out_valid_d = 1'b0;
    end
    if (word_done) begin
      if (!out_valid_q || consume) begin
        data_d      = sh_next;
        out_valid_d = 1'b1;
      end else begin
        ovr_event = 1'b1;
      end
    end
    ovr_d = (ovr_q && !Clr_Ovr) || ovr_event;
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sh_q        <= '0;
      dir_q       <= 1'b0;
      data_q      <= '0;
      out_valid_q <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sh_q        <= sh_d;
      dir_q       <= dir_d;
      data_q      <= data_d;
      out_valid_q <= out_valid_d;
      ovr_q       <= ovr_d;
    end
  end

endmodule

// File: tb/tb_shift_deserializer.sv
// Directed bench for shift_deserializer (WIDTH = 4) with a word scoreboard.
module tb_shift_deserializer;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         ser_in;
  logic         ser_valid;
  logic         dir;
  logic         sync;
  logic         out_ready;
  logic         clr_ovr;
  logic [W-1:0] data_out;
  logic         out_valid;
  logic         busy;
  logic         overrun;

  logic [W-1:0] exp_q[$];
  int           n_vec = 0;
  int           n_err = 0;

  shift_deserializer #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .Ser_In    (ser_in),
    .Ser_Valid (ser_valid),
    .Dir       (dir),
    .Sync      (sync),
    .Out_Ready (out_ready),
    .Clr_Ovr   (clr_ovr),
    .Data_Out  (data_out),
    .Out_Valid (out_valid),
    .Busy      (busy),
    .Overrun   (overrun)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after posedge; the bit is sampled on the next posedge.
  task automatic drive_bit(input logic b, input logic d, input logic s);
    @(posedge clk);
    #1;
    ser_in    = b;
    ser_valid = 1'b1;
    dir       = d;
    sync      = s;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      ser_in    = 1'b0;
      ser_valid = 1'b0;
      sync      = 1'b0;
    end
  endtask

  task automatic send4(input logic [3:0] bits, input logic d);
    for (int i = 3; i >= 0; i--) drive_bit(bits[i], d, 1'b0);
  endtask

  // Monitor: every word taken by the consumer is checked against the queue.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL word_unexpected: got %0h, expected none", data_out);
      end else begin
        check("word", data_out, exp_q.pop_front());
      end
    end
  end

  initial begin
    rst = 1'b1; ser_in = 1'b0; ser_valid = 1'b0; dir = 1'b1; sync = 1'b0;
    out_ready = 1'b1; clr_ovr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_data", data_out, 0);
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_ovr", overrun, 0);
    rst = 1'b0;
    idle(1);

    // MSB-first 1,0,1,1 -> 1011, valid for exactly one cycle.
    exp_q.push_back(4'b1011);
    send4(4'b1011, 1'b1);
    check("t1_valid_pre", out_valid, 0);
    idle(1);
    check("t1_valid_on", out_valid, 1);
    check("t1_data", data_out, 4'b1011);
    idle(1);
    check("t1_valid_off", out_valid, 0);

    // LSB-first 1,0,1,1 -> 1101.
    exp_q.push_back(4'b1101);
    send4(4'b1011, 1'b0);
    idle(1);
    check("t2_data", data_out, 4'b1101);
    idle(1);

    // Consumer stalled: 1000 held, 0111 dropped, Overrun sticky then cleared.
    out_ready = 1'b0;
    exp_q.push_back(4'b1000);
    send4(4'b1000, 1'b1);
    send4(4'b0111, 1'b1);
    check("t3_ovr_pre", overrun, 0);
    idle(1);
    check("t3_ovr_set", overrun, 1);
    check("t3_hold", data_out, 4'b1000);
    check("t3_valid", out_valid, 1);
    @(posedge clk); #1;
    clr_ovr = 1'b1;
    check("t3_ovr_sticky", overrun, 1);
    @(posedge clk); #1;
    clr_ovr = 1'b0;
    check("t3_ovr_clr", overrun, 0);
    out_ready = 1'b1;
    idle(1);
    check("t3_valid_off", out_valid, 0);

    // Word completes on the same cycle the pending word is taken.
    out_ready = 1'b0;
    exp_q.push_back(4'b0101);
    exp_q.push_back(4'b1001);
    send4(4'b0101, 1'b1);
    drive_bit(1'b1, 1'b1, 1'b0);
    drive_bit(1'b0, 1'b1, 1'b0);
    drive_bit(1'b0, 1'b1, 1'b0);
    drive_bit(1'b1, 1'b1, 1'b0);
    out_ready = 1'b1;
    idle(1);
    check("t4_valid", out_valid, 1);
    check("t4_data", data_out, 4'b1001);
    check("t4_ovr", overrun, 0);
    idle(1);
    check("t4_valid_off", out_valid, 0);

    // Sync mid-word: 1,1, then Sync+0, then 1,1,0 -> 0110.
    exp_q.push_back(4'b0110);
    check("t5_busy_pre", busy, 0);
    drive_bit(1'b1, 1'b1, 1'b0);
    drive_bit(1'b1, 1'b1, 1'b0);
    check("t5_busy_b1", busy, 1);
    drive_bit(1'b0, 1'b1, 1'b1);
    check("t5_busy_b2", busy, 1);
    drive_bit(1'b1, 1'b1, 1'b0);
    check("t5_busy_sync", busy, 1);
    drive_bit(1'b1, 1'b1, 1'b0);
    drive_bit(1'b0, 1'b1, 1'b0);
    idle(1);
    check("t5_busy_post", busy, 0);
    check("t5_data", data_out, 4'b0110);
    idle(1);

    // Gaps between bits and Dir toggled after the first bit -> 1011.
    exp_q.push_back(4'b1011);
    drive_bit(1'b1, 1'b1, 1'b0);
    idle(2);
    check("t6_busy_gap", busy, 1);
    drive_bit(1'b0, 1'b0, 1'b0);
    drive_bit(1'b1, 1'b0, 1'b0);
    idle(3);
    drive_bit(1'b1, 1'b0, 1'b0);
    idle(1);
    check("t6_data", data_out, 4'b1011);
    idle(1);

    // Reset with a pending word and a partial word; next word 0011.
    out_ready = 1'b0;
    send4(4'b1110, 1'b1);
    idle(1);
    check("t7_pending", data_out, 4'b1110);
    drive_bit(1'b1, 1'b1, 1'b0);
    drive_bit(1'b1, 1'b1, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    ser_valid = 1'b0;
    @(posedge clk); #1;
    check("t7_rst_data", data_out, 0);
    check("t7_rst_valid", out_valid, 0);
    check("t7_rst_busy", busy, 0);
    check("t7_rst_ovr", overrun, 0);
    rst = 1'b0;
    out_ready = 1'b1;
    exp_q.push_back(4'b0011);
    send4(4'b0011, 1'b1);
    idle(1);
    check("t7_data", data_out, 4'b0011);
    idle(3);

    check("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/shift_deserializer.md
SHIFT_DESERIALIZER -- requirements
Module: shift_deserializer

Interface
REQ-001 Parameter: WIDTH, default 4, word width in bits (WIDTH >= 2).
REQ-002 Ports shall be, in order:
- clk  input  1  single clock; all state changes on posedge clk.
- rst  input  1  reset; synchronous, active-high.
- Ser_In  input  1  serial data bit.
- Ser_Valid  input  1  Ser_In is valid this cycle.
- Dir  input  1  bit order: 1 = MSB-first, 0 = LSB-first.
- Sync  input  1  frame start; discards any partial word.
- Out_Ready  input  1  consumer accepts Data_Out.
- Clr_Ovr  input  1  clears Overrun.
- Data_Out  output  WIDTH  last completed word.
- Out_Valid  output  1  Data_Out holds an unconsumed word.
- Busy  output  1  partial word in progress.
- Overrun  output  1  sticky flag: a completed word was dropped.

Function
REQ-003 The block shall contain an internal shift register sh[WIDTH-1:0], a bit counter cnt (0..WIDTH-1), a latched order bit, and an output register with valid flag.
REQ-004 The FSM shall have two states: IDLE (cnt = 0, no bits held) and SHIFT (1..WIDTH-1 bits held); Busy = (state == SHIFT).
REQ-005 A bit shall be accepted only on a cycle with Ser_Valid = 1; cycles with Ser_Valid = 0 shall leave sh, cnt and state unchanged (gaps allowed anywhere).
REQ-006 MSB-first: accepted bit enters at sh[0] and sh shifts toward MSB; LSB-first: bit enters at sh[WIDTH-1] and sh shifts toward LSB.
REQ-007 Dir shall be latched on the first accepted bit of each word (IDLE to SHIFT); Dir changes mid-word shall be ignored until the next word.
REQ-008 On the WIDTH-th accepted bit, the assembled word (including that bit) shall be written to the output register, and the FSM shall return to IDLE with cnt = 0.
REQ-009 Latency: Out_Valid = 1 and Data_Out = word on the cycle after the WIDTH-th bit is sampled.
REQ-010 Handshake: a word is consumed on a cycle with Out_Valid = 1 and Out_Ready = 1; Out_Valid then clears next cycle unless REQ-011 applies.
REQ-011 If a word completes on the same cycle that the pending word is consumed, the new word shall load and Out_Valid shall remain 1; Overrun is unaffected.
REQ-012 If a word completes while Out_Valid = 1 and Out_Ready = 0, the new word shall be discarded, Data_Out kept unchanged, and Overrun set next cycle.
REQ-013 Overrun shall remain set until Clr_Ovr = 1 or rst; if Clr_Ovr and a new overrun event occur in the same cycle, Overrun shall be 1 (set wins).
REQ-014 Sync = 1 shall clear cnt and sh; if Ser_Valid = 1 in the same cycle, that bit shall become bit 1 of a new word, with Dir latched that cycle. Sync shall not affect the output register, Out_Valid, or Overrun.
REQ-015 Data_Out shall change only on a word load; it shall be stable while Out_Valid = 1 and not consumed.

Reset
REQ-016 On rst = 1 at posedge clk: state = IDLE, cnt = 0, sh = 0, Data_Out = 0, Out_Valid = 0, Busy = 0, Overrun = 0.
REQ-017 rst shall take priority over all other inputs; a partial word in progress at reset shall be lost, and no word shall be emitted.

Structure
REQ-018 A shared package shall hold the FSM state type (IDLE, SHIFT) and the default WIDTH constant.
REQ-019 One sub-module, deser_bit_counter, shall implement cnt with clear (rst/Sync), enable (Ser_Valid), and a terminal-count output; all other logic shall stay in shift_deserializer.

Verification (WIDTH = 4)
REQ-020 Dir=1, Out_Ready=1, bits 1,0,1,1 on consecutive cycles: Data_Out=4'b1011, with Out_Valid high for exactly 1 cycle, 1 cycle after the 4th bit.
REQ-021 Dir=0, same bits 1,0,1,1: Data_Out=4'b1101.
REQ-022 Out_Ready=0, Dir=1, bits 1,0,0,0 then 0,1,1,1: Data_Out stays 4'b1000 and Overrun=1 the cycle after the 8th bit; a Clr_Ovr pulse clears Overrun.
REQ-023 Dir=1, bits 1,1, then Sync together with bit 0, then bits 1,1,0: Data_Out=4'b0110, and Busy was high from the 1st to the 3rd bit.
REQ-024 Dir=1, bits 1,0,1,1 with Ser_Valid gaps of 0-3 cycles, and Dir toggled after the 1st bit: Data_Out=4'b1011.
REQ-025 rst asserted after 2 bits, then 4 bits 0,0,1,1: all outputs are 0 during reset, and the next word is 4'b0011.
